// File: rtl/fast_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : fast_pkg                                                 |
// | Purpose   : Shared FAST types and constants: sequencer state         |
// |             encoding, circle radius/size and the radius-3 Bresenham  |
// |             ring offsets.                                            |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package fast_pkg;

  typedef enum logic [1:0] {
    FAST_IDLE  = 2'd0,
    FAST_ISSUE = 2'd1,
    FAST_DRAIN = 2'd2,
    FAST_DONE  = 2'd3
  } fast_state_e;

  localparam int FAST_RADIUS = 3;
  localparam int FAST_NRING  = 16;

  // Ring walks clockwise starting straight above the centre.
  localparam logic signed [2:0] FAST_DX [FAST_NRING] = '{
     3'sd0,  3'sd1,  3'sd2,  3'sd3,  3'sd3,  3'sd3,  3'sd2,  3'sd1,
     3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
  };

  localparam logic signed [2:0] FAST_DY [FAST_NRING] = '{
    -3'sd3, -3'sd3, -3'sd2, -3'sd1,  3'sd0,  3'sd1,  3'sd2,  3'sd3,
     3'sd3,  3'sd3,  3'sd2,  3'sd1,  3'sd0, -3'sd1, -3'sd2, -3'sd3
  };

endpackage : fast_pkg
`default_nettype wire

// File: rtl/fast_circle_offset.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fast_circle_offset                                       |
// | Purpose   : Combinational lookup of the signed (dx,dy) offset of     |
// |             ring pixel 0..15 relative to the circle centre.          |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module fast_circle_offset
  import fast_pkg::*;
(
  input  logic        [3:0] i_idx,
  output logic signed [2:0] o_dx,
  output logic signed [2:0] o_dy
);

  assign o_dx = FAST_DX[i_idx];
  assign o_dy = FAST_DY[i_idx];

endmodule : fast_circle_offset
`default_nettype wire

// File: rtl/fast_circle_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fast_circle_fetch                                        |
// | Purpose   : Reads the centre pixel and the 16 radius-3 ring pixels   |
// |             of a candidate corner from the image SRAM and presents   |
// |             them as one packed result. Edge centres are rejected     |
// |             without touching the SRAM.                               |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module fast_circle_fetch
  import fast_pkg::*;
#(
  parameter  int PIXEL_DEPTH = 8,
  parameter  int X_MAX       = 200,
  parameter  int Y_MAX       = 200,
  localparam int XW          = $clog2(X_MAX),
  localparam int YW          = $clog2(Y_MAX)
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [XW-1:0]                     req_x,
  input  logic [YW-1:0]                     req_y,
  output logic [XW-1:0]                     sram_x,
  output logic [YW-1:0]                     sram_y,
  output logic                              sram_ren,
  input  logic [PIXEL_DEPTH-1:0]            sram_rdat,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_border,
  output logic [XW-1:0]                     out_x,
  output logic [YW-1:0]                     out_y,
  output logic [PIXEL_DEPTH-1:0]            out_center,
  output logic [FAST_NRING*PIXEL_DEPTH-1:0] out_ring
);

  localparam logic [1:0] S_IDLE  = FAST_IDLE;
  localparam logic [1:0] S_ISSUE = FAST_ISSUE;
  localparam logic [1:0] S_DRAIN = FAST_DRAIN;
  localparam logic [1:0] S_DONE  = FAST_DONE;

  // Item 0 is the centre, items 1..16 are the ring pixels.
  localparam logic [4:0] c_last_item = 5'(FAST_NRING);

  localparam logic [XW-1:0] c_x_lo = XW'(FAST_RADIUS);
  localparam logic [XW-1:0] c_x_hi = XW'(X_MAX - 1 - FAST_RADIUS);
  localparam logic [YW-1:0] c_y_lo = YW'(FAST_RADIUS);
  localparam logic [YW-1:0] c_y_hi = YW'(Y_MAX - 1 - FAST_RADIUS);

  logic [1:0]                       r_state;
  logic [4:0]                       r_k;
  logic [4:0]                       r_k_iss;
  logic [4:0]                       r_k_cap;
  logic                             r_sram_ren;
  logic                             r_ren_cap;
  logic [XW-1:0]                    r_cx;
  logic [YW-1:0]                    r_cy;
  logic [XW-1:0]                    r_sram_x;
  logic [YW-1:0]                    r_sram_y;
  logic                             r_border;
  logic [PIXEL_DEPTH-1:0]           r_center;
  logic [FAST_NRING*PIXEL_DEPTH-1:0] r_ring;

  logic                             w_centre_ok;
  logic                             w_accept;
  logic [3:0]                       w_ring_idx;
  logic [3:0]                       w_cap_idx;
  logic signed [2:0]                w_off_dx;
  logic signed [2:0]                w_off_dy;
  logic signed [2:0]                w_dx;
  logic signed [2:0]                w_dy;
  logic signed [XW:0]               w_addr_x;
  logic signed [YW:0]               w_addr_y;
  logic                             w_addr_ok;

  // Centre must leave room for the full radius on every side.
  assign w_centre_ok = (req_x >= c_x_lo) && (req_x <= c_x_hi) &&
                       (req_y >= c_y_lo) && (req_y <= c_y_hi);
  assign w_accept    = (r_state == S_IDLE) && req_valid;

  assign w_ring_idx  = 4'(r_k - 5'd1);
  assign w_cap_idx   = 4'(r_k_cap - 5'd1);

  fast_circle_offset u_offset (
    .i_idx (w_ring_idx),
    .o_dx  (w_off_dx),
    .o_dy  (w_off_dy)
  );

  assign w_dx = (r_k == 5'd0) ? 3'sd0 : w_off_dx;
  assign w_dy = (r_k == 5'd0) ? 3'sd0 : w_off_dy;

  // One spare sign bit so a bad offset could never alias onto a real pixel.
  assign w_addr_x  = $signed({1'b0, r_cx}) + $signed({{(XW-2){w_dx[2]}}, w_dx});
  assign w_addr_y  = $signed({1'b0, r_cy}) + $signed({{(YW-2){w_dy[2]}}, w_dy});
  assign w_addr_ok = !w_addr_x[XW] && !w_addr_y[YW];

  // Sequencer: accept, issue 17 back-to-back reads, wait for the last beat, hold result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_k_iss    <= '0;
      r_k_cap    <= '0;
      r_sram_ren <= 1'b0;
      r_ren_cap  <= 1'b0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_sram_x   <= '0;
      r_sram_y   <= '0;
      r_border   <= 1'b0;
    end else begin
      r_ren_cap  <= r_sram_ren;
      r_k_cap    <= r_k_iss;
      r_sram_ren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cx     <= req_x;
            r_cy     <= req_y;
            r_border <= !w_centre_ok;
            r_k      <= '0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_border) begin
            r_state <= S_DONE;
          end else begin
            r_sram_ren <= w_addr_ok;
            r_sram_x   <= w_addr_x[XW-1:0];
            r_sram_y   <= w_addr_y[YW-1:0];
            r_k_iss    <= r_k;
            if (r_k == c_last_item) begin
              r_k     <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_k <= r_k + 5'd1;
            end
          end
        end
        S_DRAIN: begin
          if (r_ren_cap && (r_k_cap == c_last_item)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result capture: cleared on accept, then filled as each read beat returns.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_center <= '0;
      r_ring   <= '0;
    end else if (w_accept) begin
      r_center <= '0;
      r_ring   <= '0;
    end else if (r_ren_cap) begin
      if (r_k_cap == 5'd0) begin
        r_center <= sram_rdat;
      end else begin
        r_ring[w_cap_idx*PIXEL_DEPTH +: PIXEL_DEPTH] <= sram_rdat;
      end
    end
  end

  // req_ready is gated by reset so nothing is offered while the block is held.
  assign req_ready  = (r_state == S_IDLE) && n_rst;
  assign out_valid  = (r_state == S_DONE);
  assign out_border = r_border;
  assign out_x      = r_cx;
  assign out_y      = r_cy;
  assign out_center = r_center;
  assign out_ring   = r_ring;
  assign sram_ren   = r_sram_ren;
  assign sram_x     = r_sram_x;
  assign sram_y     = r_sram_y;

endmodule : fast_circle_fetch
`default_nettype wire

// File: tb/tb_fast_circle_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_fast_circle_fetch                                     |
// | Purpose   : Directed self-checking bench for fast_circle_fetch with  |
// |             a behavioural SRAM and an expected-result scoreboard.    |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fast_circle_fetch;

  localparam int PD = 8;
  localparam int XW = 8;
  localparam int YW = 8;

  localparam int TB_DX [16] = '{ 0,  1,  2,  3,  3,  3,  2,  1,  0, -1, -2, -3, -3, -3, -2, -1};
  localparam int TB_DY [16] = '{-3, -3, -2, -1,  0,  1,  2,  3,  3,  3,  2,  1,  0, -1, -2, -3};

  typedef struct {
    logic [PD-1:0]    center;
    logic [16*PD-1:0] ring;
    logic             border;
    int               x;
    int               y;
  } exp_t;

  logic             clk       = 1'b0;
  logic             n_rst     = 1'b0;
  logic             req_valid = 1'b1;
  logic             req_ready;
  logic [XW-1:0]    req_x     = '0;
  logic [YW-1:0]    req_y     = '0;
  logic [XW-1:0]    sram_x;
  logic [YW-1:0]    sram_y;
  logic             sram_ren;
  logic [PD-1:0]    sram_rdat = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_border;
  logic [XW-1:0]    out_x;
  logic [YW-1:0]    out_y;
  logic [PD-1:0]    out_center;
  logic [16*PD-1:0] out_ring;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  fast_circle_fetch #(
    .PIXEL_DEPTH (PD),
    .X_MAX       (200),
    .Y_MAX       (200)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .sram_x     (sram_x),
    .sram_y     (sram_y),
    .sram_ren   (sram_ren),
    .sram_rdat  (sram_rdat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_border (out_border),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_center (out_center),
    .out_ring   (out_ring)
  );

  always #5 clk = ~clk;

  function automatic logic [PD-1:0] pix(input int x, input int y);
    return 8'((x + 3 * y) % 256);
  endfunction

  // Image SRAM preloaded with pixel(x,y) = (x + 3y) mod 256, one-cycle read.
  always @(posedge clk) begin
    if (sram_ren) sram_rdat <= pix(int'(sram_x), int'(sram_y));
  end

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    e.x      = x;
    e.y      = y;
    e.border = !(x >= 3 && x <= 196 && y >= 3 && y <= 196);
    e.center = '0;
    e.ring   = '0;
    if (!e.border) begin
      e.center = pix(x, y);
      for (int i = 0; i < 16; i++) e.ring[i*PD +: PD] = pix(x + TB_DX[i], y + TB_DY[i]);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one request and follows it to its handshake.
  task automatic run_req(input int x, input int y, input int bp);
    exp_t e;
    exp_t got;
    int   lat, ren_cnt, first_n, last_n, fx, fy, unstable, ready_hi;
    logic [PD-1:0]    s_center;
    logic [16*PD-1:0] s_ring;
    e = model(x, y);
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    req_x     = 8'(x);
    req_y     = 8'(y);
    req_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; ren_cnt = 0; first_n = 0; last_n = 0; fx = -1; fy = -1;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      if (n > 1) begin
        @(posedge clk);
        @(negedge clk);
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
      if (sram_ren) begin
        if (ren_cnt == 0) begin
          first_n = n;
          fx      = int'(sram_x);
          fy      = int'(sram_y);
        end
        ren_cnt++;
        last_n = n;
      end
      if (out_valid) lat = n;
    end
    chk("latency",   128'(lat),     128'(e.border ? 1 : 19));
    chk("ren_count", 128'(ren_cnt), 128'(e.border ? 0 : 17));
    chk("ren_last",  128'(last_n),  128'(e.border ? 0 : 17));
    if (!e.border) begin
      chk("ren_first", 128'(first_n), 128'(1));
      chk("first_x",   128'(fx),      128'(x));
      chk("first_y",   128'(fy),      128'(y));
    end
    if (lat != 0 && bp > 0) begin
      s_center = out_center;
      s_ring   = out_ring;
      unstable = 0;
      ready_hi = 0;
      for (int b = 0; b < bp; b++) begin
        @(posedge clk);
        @(negedge clk);
        if (!out_valid || out_center !== s_center || out_ring !== s_ring) unstable++;
        if (req_ready) ready_hi++;
      end
      chk("bp_stable",    128'(unstable), 128'(0));
      chk("bp_req_ready", 128'(ready_hi), 128'(0));
    end
    got = sb.pop_front();
    chk("out_center", 128'(out_center), 128'(got.center));
    chk("out_ring",   out_ring,         128'(got.ring));
    chk("out_border", 128'(out_border), 128'(got.border));
    chk("out_x",      128'(out_x),      128'(got.x));
    chk("out_y",      128'(out_y),      128'(got.y));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", 128'(out_valid), 128'(0));
    chk("post_hs_ready", 128'(req_ready), 128'(1));
  endtask

  initial begin
    int seen_valid, seen_ren;
    // Reset held with a request pending.
    #12;
    chk("rst_req_ready", 128'(req_ready),  128'(0));
    chk("rst_sram_ren",  128'(sram_ren),   128'(0));
    chk("rst_out_valid", 128'(out_valid),  128'(0));
    chk("rst_border",    128'(out_border), 128'(0));
    chk("rst_center",    128'(out_center), 128'(0));
    chk("rst_ring",      out_ring,         128'(0));
    chk("rst_sram_xy",   128'({sram_x, sram_y}), 128'(0));
    req_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_req_ready", 128'(req_ready), 128'(1));
    chk("rel_sram_ren",  128'(sram_ren),  128'(0));

    // Nominal centre with back-pressure, then borders and the far corner.
    run_req(10, 10, 6);
    run_req(2, 50, 0);
    run_req(197, 10, 0);
    run_req(196, 196, 0);

    // Reset in the middle of a fetch.
    req_x = 8'd10; req_y = 8'd10; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("midrst_ren_before", 128'(sram_ren), 128'(1));
    n_rst = 1'b0;
    #1;
    chk("midrst_ren",   128'(sram_ren),  128'(0));
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_ready", 128'(req_ready), 128'(0));
    @(negedge clk);
    n_rst = 1'b1;
    seen_valid = 0;
    seen_ren   = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_valid++;
      if (sram_ren)  seen_ren++;
    end
    chk("midrst_no_valid", 128'(seen_valid), 128'(0));
    chk("midrst_no_ren",   128'(seen_ren),   128'(0));
    run_req(20, 30, 0);

    // Back-to-back at minimum spacing.
    run_req(10, 10, 0);
    run_req(50, 60, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule : tb_fast_circle_fetch
`default_nettype wire
